// File: rtl/wb_axis_bridge.sv
// Wishbone register window to AXI-Stream bridge with TX/RX FIFOs and a bounded wait FSM.
// Define WB_AXIS_BRIDGE_TLAST_EN to carry tlast per FIFO entry.
module wb_axis_bridge #(
  parameter int          pDATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0080,
  parameter int          TX_DEPTH    = 4,
  parameter int          RX_DEPTH    = 4,
  parameter int          TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            wbs_adr_i,
  input  logic                   wb_valid,
  input  logic                   wbs_we_i,
  input  logic [pDATA_WIDTH-1:0] wbs_dat_i,
  output logic [pDATA_WIDTH-1:0] wbs_dat_o,
  output logic                   wb_ready,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TLW = TAW + 1;
  localparam int RLW = RAW + 1;
  localparam logic [31:0] ADR_TX   = BASE_ADDR;
  localparam logic [31:0] ADR_RX   = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADR_ST   = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADR_CTRL = BASE_ADDR + 32'hC;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic                   ack_q, err_q, rdy_en_q;
  logic [pDATA_WIDTH-1:0] dat_q;

  logic [TX_DEPTH-1:0][pDATA_WIDTH-1:0] tx_mem;
  logic [RX_DEPTH-1:0][pDATA_WIDTH-1:0] rx_mem;
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [TLW-1:0] tx_lvl_q;
  logic [RLW-1:0] rx_lvl_q;

  logic tx_full, tx_empty, rx_full, rx_empty, rx_head_last;
  logic sel_tx, sel_rx, sel_st, sel_ctrl;
  logic live, blocked, done, tx_push, rx_pop, rx_push, sm_hs, flush, ctrl_do;
  logic [31:0]            status;
  logic [pDATA_WIDTH-1:0] rd_data;

  assign tx_full  = tx_lvl_q == TLW'(TX_DEPTH);
  assign tx_empty = tx_lvl_q == '0;
  assign rx_full  = rx_lvl_q == RLW'(RX_DEPTH);
  assign rx_empty = rx_lvl_q == '0;

  assign sel_tx   =  wbs_we_i && (wbs_adr_i == ADR_TX);
  assign sel_rx   = !wbs_we_i && (wbs_adr_i == ADR_RX);
  assign sel_st   = !wbs_we_i && (wbs_adr_i == ADR_ST);
  assign sel_ctrl =  wbs_we_i && (wbs_adr_i == ADR_CTRL);

  // WAIT keeps evaluating the held access; it completes once the FIFO condition clears.
  assign live    = (state_q == S_IDLE && wb_valid) || (state_q == S_WAIT);
  assign blocked = (sel_tx && tx_full) || (sel_rx && rx_empty);
  assign done    = live && !blocked;
  assign tx_push = done && sel_tx;
  assign rx_pop  = done && sel_rx;
  assign ctrl_do = done && sel_ctrl;
  assign flush   = ctrl_do && wbs_dat_i[2];
  assign sm_hs   = sm_tvalid && sm_tready;
  assign rx_push = ss_tvalid && ss_tready;

  assign sm_tvalid = !tx_empty;
  assign sm_tdata  = tx_mem[tx_rp_q];
  assign ss_tready = rdy_en_q && !rx_full;
  assign wb_ready  = ack_q;
  assign wbs_dat_o = dat_q;

  assign status = {10'b0, rx_head_last, err_q, rx_empty, rx_full, tx_empty, tx_full,
                   8'(rx_lvl_q), 8'(tx_lvl_q)};

  always_comb begin
    rd_data = '0;
    if (sel_rx)      rd_data = rx_mem[rx_rp_q];
    else if (sel_st) rd_data = pDATA_WIDTH'(status);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      ack_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (wb_valid) begin
          if (blocked) begin
            state_q <= S_WAIT;
            cnt_q   <= 8'd1;
          end else begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            dat_q   <= rd_data;
            if (ctrl_do && wbs_dat_i[1]) err_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!blocked) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            dat_q   <= rd_data;
            cnt_q   <= '0;
          end else if (cnt_q == 8'(TIMEOUT)) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            dat_q   <= '0;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= wbs_dat_i;
    if (rx_push) rx_mem[rx_wp_q] <= ss_tdata;
  end

  // Flush wins over any stream-side push/pop landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_lvl_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_lvl_q <= '0;
    end else if (flush) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_lvl_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_lvl_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
      if (sm_hs)   tx_rp_q <= tx_rp_q + TAW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + RAW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RAW'(1);
      tx_lvl_q <= tx_lvl_q + TLW'(tx_push) - TLW'(sm_hs);
      rx_lvl_q <= rx_lvl_q + RLW'(rx_push) - RLW'(rx_pop);
    end
  end

`ifdef WB_AXIS_BRIDGE_TLAST_EN
  logic [TX_DEPTH-1:0] tx_last_mem;
  logic [RX_DEPTH-1:0] rx_last_mem;
  logic                pend_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_last_mem[tx_wp_q] <= pend_q;
    if (rx_push) rx_last_mem[rx_wp_q] <= ss_tlast;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        pend_q <= 1'b0;
    else if (flush)                    pend_q <= 1'b0;
    else if (ctrl_do && wbs_dat_i[0])  pend_q <= 1'b1;
    else if (tx_push)                  pend_q <= 1'b0;
  end

  assign sm_tlast     = !tx_empty && tx_last_mem[tx_rp_q];
  assign rx_head_last = !rx_empty && rx_last_mem[rx_rp_q];
`else
  logic unused_tlast;
  assign unused_tlast = ss_tlast;
  assign sm_tlast     = 1'b0;
  assign rx_head_last = 1'b0;
`endif
endmodule
